// File: rtl/rcv_pkg.sv
// Shared types and defaults for the UART receive timing/control stage.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } rcv_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_DATA_BITS    = 8;

    // Offset from the start edge to the mid-bit sample of the start bit.
    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/rcv_bit_timer.sv
// Mod-N bit-period counter; flags its terminal count, or the half-period
// terminal count when half_mode is set.
module rcv_bit_timer
    import rcv_pkg::*;
#(
    parameter int N = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic half_mode,
    output logic rollover_flag
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] FULL_TC = W'(N - 1);
    localparam logic [W-1:0] HALF_TC = W'(half_period(N) - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == FULL_TC) ? '0 : count + 1'b1;
        end
    end

    assign rollover_flag = enable && (count == (half_mode ? HALF_TC : FULL_TC));

endmodule

// File: rtl/rcv_timing_ctrl.sv
// UART receive timing/control: finds the start bit, strobes the downstream
// shift register at mid-bit for each data bit, checks the stop bit.
module rcv_timing_ctrl
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       shift_enable,
    output logic       load_buffer,
    output logic       framing_error,
    output logic       busy,
    output rcv_state_t state_dbg
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    rcv_state_t    state;
    logic          line_prev;
    logic [CW-1:0] bit_cnt;
    logic          sample_tick;
    logic          tick;
    logic          start_edge;
    logic          timer_clear;
    logic          half_mode;

    assign start_edge = (state == IDLE) && line_prev && !serial_in;
    assign half_mode  = (state == START);
    assign state_dbg  = state;

    // The timer is phased one cycle ahead of the sample grid: a tick marks the
    // cycle before a sample instant, so registered strobes land exactly on it.
    // START and STOP register the tick and sample serial_in on the next cycle.
    // Holding the timer at zero through IDLE gives value 0 at the start edge.
    assign timer_clear = ((state == IDLE) && !start_edge)
                      || ((state == START) && tick)
                      || ((state == START) && sample_tick && serial_in)
                      || ((state == STOP) && sample_tick)
                      || (state == LOAD);

    rcv_bit_timer #(
        .N (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (timer_clear),
        .enable        (1'b1),
        .half_mode     (half_mode),
        .rollover_flag (tick)
    );

    // shift_enable and load_buffer are single-cycle strobes with no back-pressure:
    // the consumer must act in the cycle they are high; they are never high together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            line_prev     <= 1'b1;
            bit_cnt       <= '0;
            sample_tick   <= 1'b0;
            shift_enable  <= 1'b0;
            load_buffer   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            line_prev    <= serial_in;
            shift_enable <= 1'b0;
            load_buffer  <= 1'b0;
            sample_tick  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state         <= START;
                        busy          <= 1'b1;
                        framing_error <= 1'b0;
                        bit_cnt       <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        sample_tick <= 1'b1;
                    end else if (sample_tick) begin
                        if (serial_in) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        shift_enable <= 1'b1;
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        sample_tick <= 1'b1;
                    end else if (sample_tick) begin
                        if (serial_in) begin
                            state       <= LOAD;
                            load_buffer <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            framing_error <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcv_timing_ctrl.sv
// Randomized bench for rcv_timing_ctrl: a frame-level model predicts every
// output transition, and a monitor matches observed transitions against it.
module tb_rcv_timing_ctrl;
    import rcv_pkg::*;

    localparam int N = 10;
    localparam int D = 8;
    localparam int H = N / 2;

    localparam logic [2:0] K_BUSY_RISE = 3'd0;
    localparam logic [2:0] K_FE_FALL   = 3'd1;
    localparam logic [2:0] K_SHIFT     = 3'd2;
    localparam logic [2:0] K_LOAD      = 3'd3;
    localparam logic [2:0] K_FE_RISE   = 3'd4;
    localparam logic [2:0] K_BUSY_FALL = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       shift_enable;
    logic       load_buffer;
    logic       framing_error;
    logic       busy;
    rcv_state_t state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic fe_model = 1'b0;

    // event word: {cycle[19:0], kind[2:0], serial bit at a shift strobe}
    logic [23:0] exp_q[$];

    logic busy_p = 1'b0;
    logic fe_p   = 1'b0;

    rcv_timing_ctrl #(
        .CLKS_PER_BIT (N),
        .DATA_BITS    (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .shift_enable  (shift_enable),
        .load_buffer   (load_buffer),
        .framing_error (framing_error),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [23:0] ev(input int c, input logic [2:0] k, input logic b);
        logic [31:0] cv;
        cv = c;
        return {cv[19:0], k, b};
    endfunction

    task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic b, input logic r);
        @(posedge clk);
        #1;
        serial_in = b;
        rst       = r;
    endtask

    task automatic idle_until(input int c);
        while (cyc < c - 1) drive(1'b1, 1'b0);
    endtask

    task automatic idle_for(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
    endtask

    // Predicts the whole frame from the line rules, then drives it.
    // glitch_len > 0: start bit only that many cycles long.
    // abort_off > 0: rst pulsed at t0+abort_off (inside the data bits).
    task automatic send_frame(input logic [15:0] data, input logic stop,
                              input int glitch_len, input int abort_off);
        int t0;
        int s;
        int r;
        logic b;
        t0 = cyc + 1;
        s  = t0 + H + (D + 1) * N;
        r  = (abort_off > 0) ? t0 + abort_off : 32'h3fff_ffff;

        exp_q.push_back(ev(t0 + 1, K_BUSY_RISE, 1'b0));
        if (fe_model) exp_q.push_back(ev(t0 + 1, K_FE_FALL, 1'b0));
        fe_model = 1'b0;

        if (glitch_len > 0) begin
            exp_q.push_back(ev(t0 + H + 1, K_BUSY_FALL, 1'b0));
            for (int i = 0; i < glitch_len; i++) drive(1'b0, 1'b0);
            return;
        end

        for (int k = 0; k < D; k++) begin
            if (t0 + H + (k + 1) * N <= r)
                exp_q.push_back(ev(t0 + H + (k + 1) * N, K_SHIFT, data[k]));
        end
        if (abort_off > 0) begin
            exp_q.push_back(ev(r + 1, K_BUSY_FALL, 1'b0));
        end else if (stop) begin
            exp_q.push_back(ev(s + 1, K_LOAD, 1'b0));
            exp_q.push_back(ev(s + 2, K_BUSY_FALL, 1'b0));
        end else begin
            exp_q.push_back(ev(s + 1, K_FE_RISE, 1'b0));
            exp_q.push_back(ev(s + 1, K_BUSY_FALL, 1'b0));
            fe_model = 1'b1;
        end

        for (int j = 0; j < (D + 2) * N; j++) begin
            if (t0 + j == r) begin
                drive(1'b1, 1'b1);
                return;
            end
            if (j < N) b = 1'b0;
            else if (j < (D + 1) * N) b = data[(j - N) / N];
            else b = stop;
            drive(b, 1'b0);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic match_event(input logic cond, input logic [2:0] kind, input logic b, input string name);
        logic [23:0] act;
        logic [23:0] exp;
        if (cond) begin
            checks++;
            act = ev(cyc, kind, b);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_%s: got event at cycle %0d, expected none", name, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (exp != act) begin
                    errors++;
                    $display("FAIL event_%s: got cycle %0d kind %0d bit %0b, expected cycle %0d kind %0d bit %0b",
                             name, act[23:4], act[3:1], act[0], exp[23:4], exp[3:1], exp[0]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][23:4]) < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: got nothing, expected cycle %0d kind %0d", exp_q[0][23:4], exp_q[0][3:1]);
                void'(exp_q.pop_front());
            end
            match_event(busy && !busy_p,           K_BUSY_RISE, 1'b0,      "busy_rise");
            match_event(!framing_error && fe_p,    K_FE_FALL,   1'b0,      "fe_fall");
            match_event(shift_enable,              K_SHIFT,     serial_in, "shift");
            match_event(load_buffer,               K_LOAD,      1'b0,      "load");
            match_event(framing_error && !fe_p,    K_FE_RISE,   1'b0,      "fe_rise");
            match_event(!busy && busy_p,           K_BUSY_FALL, 1'b0,      "busy_fall");
            if (shift_enable || load_buffer)
                check_eq("strobe_exclusive", {7'd0, shift_enable && load_buffer}, 8'd0);
        end
        busy_p <= busy;
        fe_p   <= framing_error;
    end

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        int gap;
        int last;
        rst       = 1'b1;
        serial_in = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);

        check_eq("reset_shift_enable",  {7'd0, shift_enable},  8'd0);
        check_eq("reset_load_buffer",   {7'd0, load_buffer},   8'd0);
        check_eq("reset_framing_error", {7'd0, framing_error}, 8'd0);
        check_eq("reset_busy",          {7'd0, busy},          8'd0);
        check_eq("reset_state",         {5'd0, state_dbg},     {5'd0, IDLE});
        mon_en = 1'b1;

        idle_until(100);
        send_frame(16'h00A5, 1'b1, 0, 0);          // good frame
        idle_until(300);
        send_frame(16'h0000, 1'b1, 3, 0);          // 3-cycle glitch
        idle_until(400);
        send_frame(16'h003C, 1'b0, 0, 0);          // bad stop bit
        idle_until(600);
        send_frame(16'h00C3, 1'b1, 0, 0);          // clears framing_error
        idle_until(800);
        send_frame(16'h005A, 1'b1, 0, 40);         // reset mid-DATA
        idle_until(1000);
        send_frame(16'h0081, 1'b1, 0, 0);          // aborted line recovers
        send_frame(16'h007E, 1'b1, 0, 0);          // back-to-back

        last = 0;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 19);
            gap  = $urandom_range(0, 25);
            if (last == 1 && gap < 1) gap = 1;
            if (last == 2 && gap < 10) gap = 10;
            if (last == 3 && gap < 2) gap = 2;
            idle_for(gap);
            if (kind < 14) begin
                send_frame(16'($urandom_range(0, 255)), 1'b1, 0, 0);
                last = 0;
            end else if (kind < 17) begin
                send_frame(16'($urandom_range(0, 255)), 1'b0, 0, 0);
                last = 1;
            end else if (kind < 19) begin
                send_frame(16'h0000, 1'b1, $urandom_range(1, H), 0);
                last = 2;
            end else begin
                send_frame(16'($urandom_range(0, 255)), 1'b1, 0,
                           H + ($urandom_range(0, D - 2) + 1) * N + 3);
                last = 3;
            end
        end

        drive(1'b1, 1'b1);                          // quiet-line check
        drive(1'b1, 1'b0);
        fe_model = 1'b0;
        if (framing_error) exp_q.push_back(ev(cyc, K_FE_FALL, 1'b0));
        idle_for(1000);
        check_eq("idle_busy",          {7'd0, busy},         8'd0);
        check_eq("idle_shift_enable",  {7'd0, shift_enable}, 8'd0);
        check_eq("idle_load_buffer",   {7'd0, load_buffer},  8'd0);
        check_eq("idle_state",         {5'd0, state_dbg},    {5'd0, IDLE});

        idle_for(5);
        check_eq("expected_queue_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
